ones_pattern_gen: RTL and testbench

Streaming generator for the inverse of population count: given a target ones-count `din`, it emits every DATA_WIDTH-bit word with exactly that many set bits, one per handshake, in ascending numeric order. It is the stimulus and enumeration source paired with the ones-counter datapath. Its output stream feeds that counter directly, and every emitted word must count back to the requested value.

---
 rtl/ones_pattern_gen_if.sv | 34 +++
 rtl/ones_pattern_gen.sv | 130 +++++++++++++
 tb/tb_ones_pattern_gen.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/ones_pattern_gen_if.sv
// ones_pattern_gen_if
//   Bundles the control and output-stream signals of ones_pattern_gen.
//   master: the generator side (drives the stream and status).
//   slave : the consumer / controller side.
// Signals:
//   start, din           request a new enumeration with target ones-count din
//   dout, dout_valid,
//   dout_ready, last     output word stream with backpressure and end marker
//   busy, done, err      status: enumeration running, finished/rejected, rejected
interface ones_pattern_gen_if #(
    parameter int DATA_WIDTH = 16
);
    localparam int CW = $clog2(DATA_WIDTH) + 1;

    logic                  start;
    logic [CW-1:0]         din;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  dout_ready;
    logic                  last;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        input  start, din, dout_ready,
        output dout, dout_valid, last, busy, done, err
    );

    modport slave (
        output start, din, dout_ready,
        input  dout, dout_valid, last, busy, done, err
    );
endinterface

// File: rtl/ones_pattern_gen.sv
// ones_pattern_gen
//   Enumerates every DATA_WIDTH-bit word with exactly k set bits, in
//   ascending order, one word per dout_valid/dout_ready handshake.
// Ports:
//   clk     rising-edge clock
//   resetn  synchronous active-low reset
//   bus     ones_pattern_gen_if.master: start/din request, dout stream with
//           dout_valid/dout_ready/last, busy/done/err status
module ones_pattern_gen #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                clk,
    input  logic                resetn,
    ones_pattern_gen_if.master  bus
);
    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam int SW = $clog2(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;
    localparam logic [CW-1:0]         MAX_K    = CW'(DATA_WIDTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state_q, state_n;
    logic [DATA_WIDTH-1:0] dout_q, dout_n;
    logic                  valid_q, valid_n;
    logic                  last_q, last_n;
    logic                  done_q, done_n;
    logic                  err_q, err_n;
    logic [CW-1:0]         k_q, k_n;

    // k ones packed at the bottom / top; shifting by DATA_WIDTH yields
    // zero, so k==DATA_WIDTH naturally gives all ones in both.
    function automatic logic [DATA_WIDTH-1:0] low_ones(input logic [CW-1:0] n);
        return ~(ALL_ONES << n);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] high_ones(input logic [CW-1:0] n);
        return ~(ALL_ONES >> n);
    endfunction

    // Gosper's step on the registered word. Only evaluated for a word that
    // is not the top pattern, so the add never carries out of the MSB.
    logic [DATA_WIDTH-1:0] lowest;
    logic [DATA_WIDTH-1:0] ripple;
    logic [DATA_WIDTH-1:0] next_word;
    logic [SW-1:0]         ctz;

    assign lowest = dout_q & (-dout_q);
    assign ripple = dout_q + lowest;

    // lowest is one-hot (or zero), so a priority-free scan gives its index.
    always_comb begin
        ctz = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            if (lowest[i]) begin
                ctz = SW'(i);
            end
        end
    end

    assign next_word = ripple | (((ripple ^ dout_q) >> 2) >> ctz);

    always_comb begin
        state_n = state_q;
        dout_n  = dout_q;
        valid_n = valid_q;
        last_n  = last_q;
        done_n  = 1'b0;
        err_n   = 1'b0;
        k_n     = k_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.din > MAX_K) begin
                        done_n = 1'b1;
                        err_n  = 1'b1;
                    end else begin
                        k_n     = bus.din;
                        dout_n  = low_ones(bus.din);
                        valid_n = 1'b1;
                        last_n  = (low_ones(bus.din) == high_ones(bus.din));
                        state_n = RUN;
                    end
                end
            end
            RUN: begin
                if (valid_q && bus.dout_ready) begin
                    if (last_q) begin
                        valid_n = 1'b0;
                        last_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        dout_n = next_word;
                        last_n = (next_word == high_ones(k_q));
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            dout_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_n;
            dout_q  <= dout_n;
            valid_q <= valid_n;
            last_q  <= last_n;
            done_q  <= done_n;
            err_q   <= err_n;
            k_q     <= k_n;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
    assign bus.last       = last_q;
    assign bus.busy       = (state_q == RUN);
    assign bus.done       = done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_ones_pattern_gen.sv
module tb_ones_pattern_gen;
    logic clk;
    logic resetn;

    int checks   = 0;
    int failures = 0;

    ones_pattern_gen_if #(.DATA_WIDTH(4))  b4  ();
    ones_pattern_gen_if #(.DATA_WIDTH(16)) b16 ();

    ones_pattern_gen #(.DATA_WIDTH(4)) dut4 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (b4.master)
    );

    ones_pattern_gen #(.DATA_WIDTH(16)) dut16 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (b16.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    logic [3:0]  exp4 [6];
    logic [15:0] exp16r [10];
    int          idx;
    int          t;
    int          words;
    int          bad_pop;
    int          bad_order;
    int          bad_gap;
    int          bad_busy;
    int          cyc;
    bit          finished;
    logic [15:0] w;
    logic [15:0] prev;
    logic [15:0] first_w;
    logic [15:0] last_w;

    initial begin
        exp4   = '{4'h3, 4'h5, 4'h6, 4'h9, 4'hA, 4'hC};
        exp16r = '{16'h0007, 16'h000B, 16'h000D, 16'h000E, 16'h0013,
                   16'h0015, 16'h0016, 16'h0019, 16'h001A, 16'h001C};

        resetn = 1'b0;
        b4.start = 1'b0;  b4.din = '0;  b4.dout_ready = 1'b0;
        b16.start = 1'b0; b16.din = '0; b16.dout_ready = 1'b0;
        step();
        step();
        check("rst_dout",  b4.dout, 32'h0);
        check("rst_valid", b4.dout_valid, 32'h0);
        check("rst_last",  b4.last, 32'h0);
        check("rst_busy",  b4.busy, 32'h0);
        check("rst_done",  b4.done, 32'h0);
        check("rst_err",   b4.err, 32'h0);
        check("rst16_dout", b16.dout, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        step();

        // W=4, k=2, ready always high
        @(negedge clk);
        b4.start = 1'b1; b4.din = 3'd2; b4.dout_ready = 1'b1;
        step();
        check("t1_first", b4.dout, 32'(exp4[0]));
        check("t1_valid", b4.dout_valid, 32'h1);
        check("t1_busy",  b4.busy, 32'h1);
        check("t1_last0", b4.last, 32'h0);
        @(negedge clk);
        b4.start = 1'b0;
        for (int i = 1; i < 6; i++) begin
            step();
            check("t1_word", b4.dout, 32'(exp4[i]));
            check("t1_wvalid", b4.dout_valid, 32'h1);
            check("t1_last", b4.last, (i == 5) ? 32'h1 : 32'h0);
        end
        step();
        check("t1_done",   b4.done, 32'h1);
        check("t1_dvalid", b4.dout_valid, 32'h0);
        check("t1_dbusy",  b4.busy, 32'h0);
        check("t1_derr",   b4.err, 32'h0);
        step();
        check("t1_done_drop", b4.done, 32'h0);

        // W=4, k=2, ready pattern 1,0,0 repeating
        @(negedge clk);
        b4.start = 1'b1; b4.din = 3'd2; b4.dout_ready = 1'b0;
        step();
        idx = 0;
        t = 0;
        while (idx < 6 && t < 40) begin
            check("t2_word",  b4.dout, 32'(exp4[idx]));
            check("t2_valid", b4.dout_valid, 32'h1);
            check("t2_last",  b4.last, (idx == 5) ? 32'h1 : 32'h0);
            @(negedge clk);
            b4.start = 1'b0;
            b4.dout_ready = (t % 3 == 0);
            step();
            if (b4.dout_ready) idx++;
            t++;
        end
        check("t2_count", idx, 32'd6);
        check("t2_done",  b4.done, 32'h1);
        check("t2_valid_off", b4.dout_valid, 32'h0);

        // W=4, k=0 then k=4, second start in the done cycle
        @(negedge clk);
        b4.start = 1'b1; b4.din = 3'd0; b4.dout_ready = 1'b1;
        step();
        check("t3_k0_word",  b4.dout, 32'h0);
        check("t3_k0_valid", b4.dout_valid, 32'h1);
        check("t3_k0_last",  b4.last, 32'h1);
        @(negedge clk);
        b4.din = 3'd4;
        step();
        check("t3_k0_done",  b4.done, 32'h1);
        check("t3_k0_busy",  b4.busy, 32'h0);
        check("t3_k0_vld",   b4.dout_valid, 32'h0);
        step();
        check("t3_k4_word",  b4.dout, 32'hF);
        check("t3_k4_valid", b4.dout_valid, 32'h1);
        check("t3_k4_last",  b4.last, 32'h1);
        check("t3_k4_ndone", b4.done, 32'h0);
        @(negedge clk);
        b4.start = 1'b0;
        step();
        check("t3_k4_done", b4.done, 32'h1);
        check("t3_k4_vld",  b4.dout_valid, 32'h0);
        step();

        // W=4, din=5 rejected
        @(negedge clk);
        b4.start = 1'b1; b4.din = 3'd5;
        step();
        check("t4_done",  b4.done, 32'h1);
        check("t4_err",   b4.err, 32'h1);
        check("t4_valid", b4.dout_valid, 32'h0);
        check("t4_busy",  b4.busy, 32'h0);
        @(negedge clk);
        b4.start = 1'b0;
        step();
        check("t4_done_drop", b4.done, 32'h0);
        check("t4_err_drop",  b4.err, 32'h0);
        check("t4_valid2",    b4.dout_valid, 32'h0);

        // W=16, k=8, full enumeration with stray start pulses
        @(negedge clk);
        b16.start = 1'b1; b16.din = 5'd8; b16.dout_ready = 1'b1;
        step();
        words = 0; bad_pop = 0; bad_order = 0; bad_gap = 0; bad_busy = 0;
        cyc = 0; finished = 1'b0; prev = '0; first_w = '0; last_w = '0;
        while (!finished && cyc < 13000) begin
            if (b16.dout_valid) begin
                w = b16.dout;
                if (words == 0) first_w = w;
                else if (w <= prev) bad_order++;
                if ($countones(w) != 8) bad_pop++;
                if (!b16.busy) bad_busy++;
                prev = w;
                words++;
                if (b16.last) begin
                    finished = 1'b1;
                    last_w = w;
                end
            end else begin
                bad_gap++;
            end
            @(negedge clk);
            b16.start = 1'($urandom_range(0, 1));
            b16.din = 5'd3;
            step();
            cyc++;
        end
        check("t5_finished", 32'(finished), 32'h1);
        check("t5_done",     b16.done, 32'h1);
        check("t5_count",    words, 32'd12870);
        check("t5_popcount_bad", bad_pop, 32'd0);
        check("t5_order_bad", bad_order, 32'd0);
        check("t5_bubbles",  bad_gap, 32'd0);
        check("t5_busy_bad", bad_busy, 32'd0);
        check("t5_first",    first_w, 32'h00FF);
        check("t5_last",     last_w, 32'hFF00);
        @(negedge clk);
        b16.start = 1'b0;
        step();

        // W=16, k=3, reset after 10 words
        @(negedge clk);
        b16.start = 1'b1; b16.din = 5'd3; b16.dout_ready = 1'b1;
        step();
        @(negedge clk);
        b16.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("t6_word", b16.dout, 32'(exp16r[i]));
            if (i < 9) step();
        end
        @(negedge clk);
        resetn = 1'b0;
        step();
        check("t6_rst_dout",  b16.dout, 32'h0);
        check("t6_rst_valid", b16.dout_valid, 32'h0);
        check("t6_rst_last",  b16.last, 32'h0);
        check("t6_rst_busy",  b16.busy, 32'h0);
        check("t6_rst_done",  b16.done, 32'h0);
        check("t6_rst_err",   b16.err, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        step();
        check("t6_no_done", b16.done, 32'h0);
        @(negedge clk);
        b16.start = 1'b1; b16.din = 5'd3;
        step();
        check("t6_restart", b16.dout, 32'h0007);
        check("t6_restart_valid", b16.dout_valid, 32'h1);
        @(negedge clk);
        b16.start = 1'b0;
        step();
        check("t6_second", b16.dout, 32'h000B);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
